kbd_ps2_decoder: RTL
====================

# kbd_ps2_decoder

PS/2 keyboard receiver and scan-code decoder that produces the `key_space`, `key_left` and `key_right` level signals consumed by the game control logic. It samples the raw PS/2 clock/data lines and deserializes 11-bit device-to-host frames. It tracks make/break (`F0`) and extended (`E0`) prefixes and holds each key output high while the corresponding key is pressed. It sits between the board PS/2 pins and the character control block, in the 100 MHz system clock domain.

## Interface
Parameters:
- `CLK_FREQ`, 100_000_000: system clock frequency in Hz.
- `TIMEOUT_US`, 200: maximum gap between PS/2 falling edges inside a frame, in µs. `TIMEOUT_CYCLES = CLK_FREQ/1_000_000*TIMEOUT_US`.
- `FILTER_LEN`, 8: number of consecutive equal synchronized samples required before the filtered `ps2_clk` changes state.

Ports:
- `clk` input 1: system clock, all logic on its rising edge.
- `rst_n` input 1: reset, asynchronous and active-low. One clock; reset is asynchronous and active-low.
- `ps2_clk` input 1: raw PS/2 clock, asynchronous to `clk`.
- `ps2_data` input 1: raw PS/2 data, asynchronous to `clk`.
- `key_space` output 1: high while Space (`29`) is held.
- `key_left` output 1: high while Left Arrow (`E0 6B`) is held.
- `key_right` output 1: high while Right Arrow (`E0 74`) is held.
- `scan_code` output 8: last received byte; holds its value until the next byte arrives.
- `scan_valid` output 1: one-cycle pulse when `scan_code` updates.
- `frame_err` output 1: one-cycle pulse on a discarded frame.

## Operation
- **Input conditioning.** `ps2_clk` and `ps2_data` each pass through a 2-FF synchronizer. Synchronized `ps2_clk` then passes a saturating filter of length `FILTER_LEN`. A falling edge of the filtered clock produces a one-cycle `fall` strobe. Data is sampled from synchronized `ps2_data` on `fall`.
- **Frame FSM.** States IDLE, DATA, PARITY, STOP.
  - IDLE: on `fall` with data 0 (start bit) go to DATA and clear the bit counter. On `fall` with data 1, stay in IDLE with no error.
  - DATA: shift in 8 bits, LSB first. After the 8th bit go to PARITY.
  - PARITY: capture the parity bit, then go to STOP.
  - STOP: if data is 1 and parity is OK, load `scan_code` and pulse `scan_valid`. If data is 0, pulse `frame_err`. Either way return to IDLE.
- **Timeout.** A timeout counter resets on every `fall`. In any state other than IDLE, reaching `TIMEOUT_CYCLES` causes:
  - a return to IDLE;
  - the partial frame is discarded;
  - `frame_err` pulses;
  - the prefix flags are cleared.
- **Decoder.** Holds flags `ext` and `brk`, updated on `scan_valid`:
  - `E0` sets `ext`.
  - `F0` sets `brk`.
  - Any other byte is applied as the code (make if `brk`=0, break if `brk`=1), then clears both flags.
  - Applied code `29` with `ext`=0 drives `key_space` (make→1, break→0).
  - Applied code `6B` with `ext`=1 drives `key_left`; `74` with `ext`=1 drives `key_right`.
  - `6B`/`74` without `ext` (keypad) and `29` with `ext` change nothing.
- **Simultaneous keys.** Key outputs are independent; any combination may be high at once.
- **Reset.** Reset mid-frame or mid-prefix asynchronously clears everything. Reset values:
  - all outputs 0, including `scan_code`=`00`;
  - FSM in IDLE;
  - flags and counters cleared.

## Timing
- Latency from a raw `ps2_clk` falling edge to `fall` is 2 sync cycles plus `FILTER_LEN` cycles plus 1 edge-detect cycle, i.e. 11 cycles at default settings.
- `scan_valid` and `frame_err` are registered and assert in the cycle after the stop-bit `fall`.
- Key outputs update in the cycle after `scan_valid`.
- `scan_valid` and `frame_err` never assert in the same cycle.
- Back-to-back frames need no idle gap beyond the device's own stop bit.

## Configuration
- `KBD_PARITY_CHECK_EN` defined: parity must be odd over the 8 data bits plus the parity bit. On a mismatch at STOP:
  - the byte is dropped (no `scan_valid`);
  - `frame_err` pulses;
  - the prefix flags are cleared.
- Not defined: the parity bit is sampled and ignored. Only the stop bit and the timeout generate `frame_err`.

## Test plan
- Reset with `rst_n`=0 mid-frame → all outputs 0 immediately. After release, a valid frame for `29` is still accepted.
- Frame sequence `29`, then `F0 29` → `key_space` rises 1 cycle after the first `scan_valid` and falls 1 cycle after the `scan_valid` for the second `29`. `key_left`/`key_right` stay 0 throughout.
- Sequence `E0 74`, `E0 6B`, `E0 F0 74` → `key_right`=1, then `key_left`=1 with both high together, then `key_right`=0 while `key_left` remains 1.
- Sequence `6B` without prefix → `scan_valid` pulses with `scan_code`=`6B`; all key outputs unchanged.
- Frame `29` with the stop bit forced to 0 → `frame_err` pulses once, no `scan_valid`. With the macro on, a frame with bad parity gives the same response; with the macro off, that frame yields `scan_valid`.
- Clock edges stop after 4 data bits for more than `TIMEOUT_CYCLES` → `frame_err` pulses and the FSM returns to IDLE. The next complete frame `29` sets `key_space`.

Source files
------------

// File: rtl/kbd_ps2_decoder.sv
// kbd_ps2_decoder: PS/2 keyboard receiver and scan-code decoder.
// Samples raw PS/2 clock/data, deserializes 11-bit device-to-host frames and
// turns Space / Left Arrow / Right Arrow make/break sequences into level
// outputs. Optional feature macro: KBD_PARITY_CHECK_EN (odd parity enforced).
module kbd_ps2_decoder #(
  parameter int CLK_FREQ   = 100_000_000,
  parameter int TIMEOUT_US = 200,
  parameter int FILTER_LEN = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic       key_space,
  output logic       key_left,
  output logic       key_right,
  output logic [7:0] scan_code,
  output logic       scan_valid,
  output logic       frame_err
);

  localparam int TIMEOUT_CYCLES = CLK_FREQ / 1_000_000 * TIMEOUT_US;
  localparam int TO_W           = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_DATA   = 2'd1;
  localparam logic [1:0] S_PARITY = 2'd2;
  localparam logic [1:0] S_STOP   = 2'd3;

  localparam logic [7:0] CODE_EXT   = 8'hE0;
  localparam logic [7:0] CODE_BRK   = 8'hF0;
  localparam logic [7:0] CODE_SPACE = 8'h29;
  localparam logic [7:0] CODE_LEFT  = 8'h6B;
  localparam logic [7:0] CODE_RIGHT = 8'h74;

  logic                  ps2_clk_p0, ps2_clk_p1;
  logic                  ps2_data_p0, ps2_data_p1;
  logic [FILTER_LEN-1:0] clk_hist_p2;
  logic                  clk_filt_p2, clk_filt_p3;
  logic                  fall;

  logic [1:0]            state;
  logic [2:0]            bit_cnt;
  logic [7:0]            shreg;
  logic [TO_W-1:0]       to_cnt;
  logic                  to_hit;
  logic                  par_ok;
  logic                  flag_clr;
  logic                  ext, brk;

  // Two-flop synchronizers; lines idle high so reset to 1
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ps2_clk_p0  <= 1'b1;
      ps2_clk_p1  <= 1'b1;
      ps2_data_p0 <= 1'b1;
      ps2_data_p1 <= 1'b1;
    end else begin
      ps2_clk_p0  <= ps2_clk;
      ps2_clk_p1  <= ps2_clk_p0;
      ps2_data_p0 <= ps2_data;
      ps2_data_p1 <= ps2_data_p0;
    end
  end

  // Glitch filter: output only follows a run of FILTER_LEN equal samples
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clk_hist_p2 <= '1;
      clk_filt_p2 <= 1'b1;
      clk_filt_p3 <= 1'b1;
    end else begin
      clk_hist_p2 <= {clk_hist_p2[FILTER_LEN-2:0], ps2_clk_p1};
      if (&clk_hist_p2)
        clk_filt_p2 <= 1'b1;
      else if (~|clk_hist_p2)
        clk_filt_p2 <= 1'b0;
      clk_filt_p3 <= clk_filt_p2;
    end
  end

  // ---- stage boundary: filtered clock -> falling-edge strobe ----
  assign fall   = clk_filt_p3 & ~clk_filt_p2;
  assign to_hit = (state != S_IDLE) && (to_cnt == TO_W'(TIMEOUT_CYCLES));

`ifdef KBD_PARITY_CHECK_EN
  logic par_bit;

  // Parity bit is kept only when it is actually checked
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      par_bit <= 1'b0;
    else if (fall && state == S_PARITY)
      par_bit <= ps2_data_p1;
  end

  assign par_ok = ^{shreg, par_bit};
`else
  assign par_ok = 1'b1;
`endif

  // Inter-edge timeout counter; parked at zero while idle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      to_cnt <= '0;
    else if (fall || state == S_IDLE)
      to_cnt <= '0;
    else if (!to_hit)
      to_cnt <= to_cnt + TO_W'(1);
  end

  // Frame FSM: start, 8 data bits LSB first, parity, stop
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      bit_cnt    <= 3'd0;
      shreg      <= 8'h00;
      scan_code  <= 8'h00;
      scan_valid <= 1'b0;
      frame_err  <= 1'b0;
      flag_clr   <= 1'b0;
    end else begin
      scan_valid <= 1'b0;
      frame_err  <= 1'b0;
      flag_clr   <= 1'b0;
      if (to_hit) begin
        // Stalled frame: drop it and forget any pending prefix
        state     <= S_IDLE;
        frame_err <= 1'b1;
        flag_clr  <= 1'b1;
      end else if (fall) begin
        case (state)
          S_IDLE: begin
            if (!ps2_data_p1) begin
              state   <= S_DATA;
              bit_cnt <= 3'd0;
            end
          end
          S_DATA: begin
            shreg   <= {ps2_data_p1, shreg[7:1]};
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7)
              state <= S_PARITY;
          end
          S_PARITY: begin
            state <= S_STOP;
          end
          default: begin
            state <= S_IDLE;
            if (!ps2_data_p1) begin
              frame_err <= 1'b1;
            end else if (!par_ok) begin
              frame_err <= 1'b1;
              flag_clr  <= 1'b1;
            end else begin
              scan_code  <= shreg;
              scan_valid <= 1'b1;
            end
          end
        endcase
      end
    end
  end

  // ---- stage boundary: received byte -> prefix tracking and key levels ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ext       <= 1'b0;
      brk       <= 1'b0;
      key_space <= 1'b0;
      key_left  <= 1'b0;
      key_right <= 1'b0;
    end else if (flag_clr) begin
      ext <= 1'b0;
      brk <= 1'b0;
    end else if (scan_valid) begin
      case (scan_code)
        CODE_EXT: ext <= 1'b1;
        CODE_BRK: brk <= 1'b1;
        default: begin
          // Keypad 6B/74 (no E0) and E0 29 fall through untouched
          if (!ext && scan_code == CODE_SPACE) key_space <= !brk;
          if (ext && scan_code == CODE_LEFT)   key_left  <= !brk;
          if (ext && scan_code == CODE_RIGHT)  key_right <= !brk;
          ext <= 1'b0;
          brk <= 1'b0;
        end
      endcase
    end
  end

endmodule
